// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage, decoder and PCU.
// The package holds the default widths, the NOP opcode and the fetch state encoding.
package fetch_unit_pkg;

  localparam int DEFAULT_ADDR_W  = 12;
  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_TIMEOUT = 15;

  // Opcode that the instruction register holds after reset or a squashed fetch.
  localparam logic [7:0] NOP_OPCODE = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ERROR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the PCU-side, program-memory-side and decoder-side signals of the fetch stage.
//
// Memory handshake: mem_req is high for as long as a read is outstanding, and
// mem_addr is held stable for that whole time. A read completes in the cycle
// where mem_req and mem_ack are both high. mem_rdata is only meaningful in that
// cycle. The memory may keep mem_ack low to insert wait states. If mem_req drops
// without an ack, the memory abandons the read.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [ADDR_W-1:0] address;
  logic              branch;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instruction_out;
  logic              instr_valid;
  logic              stall;
  logic              fetch_error;
  fetch_state_t      state;

  // Fetch unit side.
  modport master (
    input  address, branch, mem_ack, mem_rdata,
    output mem_addr, mem_req, instruction_out, instr_valid, stall, fetch_error, state
  );

  // Environment side: the PCU, the decoder and the program memory.
  modport slave (
    output address, branch, mem_ack, mem_rdata,
    input  mem_addr, mem_req, instruction_out, instr_valid, stall, fetch_error, state
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It reads the byte at the PCU address from program memory
// using a req/ack handshake. The returned byte is latched into the instruction
// register. The PCU is held while memory is busy, a wrong-path byte is squashed on a
// taken jump, and the stage locks into ERROR if memory never answers.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               ADDR_W   = DEFAULT_ADDR_W,
  parameter int               DATA_W   = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(NOP_OPCODE),
  parameter int               TIMEOUT  = DEFAULT_TIMEOUT
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              error_q;
  logic [DATA_W-1:0] insn_q;
  logic              valid_q;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fire;
  logic              timeout_hit;

  // The PCU keeps address stable while stalled, so it can feed memory directly.
  assign fetch_addr   = bus.address;
  assign bus.mem_addr = fetch_addr;

  assign fire = (state == REQ) && bus.mem_ack;

  // This is the last wait cycle allowed. An ack in this same cycle still wins.
  assign timeout_hit = (state == REQ) && !bus.mem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // The request is a decode of the async-reset state register, so reset drops it at once.
  assign bus.mem_req         = (state == REQ);
  assign bus.stall           = !fire;
  assign bus.fetch_error     = error_q;
  assign bus.instruction_out = insn_q;
  assign bus.instr_valid     = valid_q;
  assign bus.state           = state;

  // Fetch control: IDLE settle cycle, request and wait counting, and a sticky timeout lock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          wait_cnt <= '0;
        end
        REQ: begin
          if (bus.mem_ack) begin
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state    <= ERROR;
            wait_cnt <= CNT_W'(TIMEOUT);
            error_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ERROR: begin
          state   <= ERROR;
          error_q <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Instruction register: loads on fire, loads NOP on a taken jump, and holds across stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      insn_q  <= NOP_INSN;
      valid_q <= 1'b0;
    end else if (fire) begin
      if (bus.branch) begin
        insn_q  <= NOP_INSN;
        valid_q <= 1'b0;
      end else begin
        insn_q  <= bus.mem_rdata;
        valid_q <= 1'b1;
      end
    end else if (timeout_hit) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed fetch sequences with a scoreboard of expected
// {instr_valid, instruction_out} pairs, checked the cycle after every fire.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  logic clock;
  logic reset;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NOP_INSN(8'h00),
    .TIMEOUT (15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total  = 0;
  int passed = 0;
  logic [DATA_W:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    total++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock cycle: drive inputs just after the rising edge and return at the falling edge.
  task automatic step(input logic [ADDR_W-1:0] a, input logic br, input logic ack,
                      input logic [DATA_W-1:0] rd, input logic push, input logic [DATA_W:0] exp);
    @(posedge clock);
    #1;
    bus.address   = a;
    bus.branch    = br;
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;
    if (push) exp_q.push_back(exp);
    @(negedge clock);
  endtask

  // Zero-wait fetch of a real instruction.
  task automatic fetch_ok(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] rd);
    step(a, 1'b0, 1'b1, rd, 1'b1, {1'b1, rd});
    check("fetch_stall", 32'(bus.stall), 32'd0);
    check("fetch_addr", 32'(bus.mem_addr), 32'(a));
  endtask

  // Fetch with a taken jump in the fire cycle: the byte must be squashed.
  task automatic fetch_jump(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] rd);
    step(a, 1'b1, 1'b1, rd, 1'b1, {1'b0, 8'h00});
    check("jump_stall", 32'(bus.stall), 32'd0);
  endtask

  // Wait-state cycle: request held, PCU stalled, instruction register held.
  task automatic wait_cyc(input logic [ADDR_W-1:0] a, input logic br,
                          input logic [DATA_W-1:0] held);
    step(a, br, 1'b0, 8'hBD, 1'b0, '0);
    check("wait_stall", 32'(bus.stall), 32'd1);
    check("wait_req", 32'(bus.mem_req), 32'd1);
    check("wait_addr", 32'(bus.mem_addr), 32'(a));
    check("wait_hold", 32'(bus.instruction_out), 32'(held));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_insn"}, 32'(bus.instruction_out), 32'h00);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd1);
    check({tag, "_error"}, 32'(bus.fetch_error), 32'd0);
  endtask

  // Release reset just after a rising edge; the following cycle is the IDLE settle cycle.
  task automatic release_reset(input logic [ADDR_W-1:0] a);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.address   = a;
    bus.branch    = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hE5;
    @(negedge clock);
    check("idle_stall", 32'(bus.stall), 32'd1);
    check("idle_req", 32'(bus.mem_req), 32'd0);
    check("idle_state", 32'(bus.state), 32'(IDLE));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic pending;
    logic [DATA_W:0] exp;
    pending = 1'b0;
    forever begin
      @(negedge clock);
      if (pending) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_fire: got insn 0x%0h valid %0d with nothing expected",
                   bus.instruction_out, bus.instr_valid);
        end else begin
          exp = exp_q.pop_front();
          check("sb_insn", 32'({bus.instr_valid, bus.instruction_out}), 32'(exp));
        end
      end
      pending = bus.mem_req && bus.mem_ack;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    bus.address   = '0;
    bus.branch    = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_values("rst");
    check("rst_state", 32'(bus.state), 32'(IDLE));

    // Zero-wait memory, PCU counting up from 0.
    release_reset(12'h000);
    for (int i = 0; i < 5; i++) fetch_ok(12'(i), 8'(i));

    // Three wait states on 0x005; branch during a wait cycle is ignored.
    wait_cyc(12'h005, 1'b0, 8'h04);
    wait_cyc(12'h005, 1'b1, 8'h04);
    wait_cyc(12'h005, 1'b0, 8'h04);
    fetch_ok(12'h005, 8'h05);

    // Taken jump to 0x3A0 while memory returns 0x77.
    fetch_jump(12'h006, 8'h77);
    fetch_ok(12'h3A0, 8'hA0);

    // Back-to-back taken jumps.
    fetch_jump(12'h3A1, 8'h55);
    fetch_jump(12'h100, 8'h66);
    fetch_ok(12'h200, 8'h12);

    // Address wrap.
    fetch_ok(12'hFFF, 8'hEE);
    fetch_ok(12'h000, 8'h11);

    // Ack arrives on the 15th request cycle: normal fire.
    for (int i = 0; i < 14; i++) wait_cyc(12'h020, 1'b0, 8'h11);
    fetch_ok(12'h020, 8'h20);
    check("late_ack_error", 32'(bus.fetch_error), 32'd0);

    // Ack withheld for 15 cycles: timeout.
    for (int i = 0; i < 15; i++) wait_cyc(12'h021, 1'b0, 8'h20);
    check("pre_timeout_error", 32'(bus.fetch_error), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(12'h021, 1'b0, 1'b1, 8'h21, 1'b0, '0);
      check("err_flag", 32'(bus.fetch_error), 32'd1);
      check("err_req", 32'(bus.mem_req), 32'd0);
      check("err_stall", 32'(bus.stall), 32'd1);
      check("err_valid", 32'(bus.instr_valid), 32'd0);
      check("err_state", 32'(bus.state), 32'(ERROR));
    end

    // Reset recovers from ERROR.
    #2 reset = 1'b1;
    #1 check_reset_values("err_rst");

    // Async reset pulse in the middle of a wait state.
    release_reset(12'h004);
    fetch_ok(12'h004, 8'h9C);
    wait_cyc(12'h005, 1'b0, 8'h9C);
    wait_cyc(12'h005, 1'b0, 8'h9C);
    #2 reset = 1'b1;
    #1 check_reset_values("mid_rst");
    check("mid_rst_state", 32'(bus.state), 32'(IDLE));

    // Fetch restarts from IDLE.
    release_reset(12'h040);
    fetch_ok(12'h040, 8'h5A);
    step(12'h041, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
